// File: rtl/wbu.sv
// wbu: writeback/resolve stage -- 2-entry input FIFO feeding an IDLE/REDIR FSM that drives the
// GPR write port and holds PC redirects until accepted. Define WBU_ILLEGAL_CHK_EN for the illegal flag.
module wbu #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] exu_data,
    input  logic [3:0]      wb_op,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            gpr_wen,
    output logic [4:0]      gpr_waddr,
    output logic [XLEN-1:0] gpr_wdata,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            illegal
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [3:0]      op;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
    } entry_t;

    typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} state_e;

    entry_t          mem_q [DEPTH];
    entry_t          head_s;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    state_e          state_q, state_d;
    logic            wen_q, wen_d, rv_q, rv_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d, rpc_q, rpc_d;
    logic            push_s, pop_s, flush_s, full_s, empty_s;
    logic            cmp_eq_s, cmp_gt_s, cmp_lt_s;
    logic            dec_wr_s, dec_redir_s;
    logic [XLEN-1:0] dec_wdata_s, dec_tgt_s, pc4_s, bt_s;

    assign full_s   = (count_q == CW'(DEPTH));
    assign empty_s  = (count_q == {CW{1'b0}});
    assign in_ready = rst_n && !full_s && (state_q == IDLE);
    assign push_s   = in_valid && in_ready;
    assign head_s   = mem_q[rd_ptr_q];

    // Decode the FIFO head: writeback value and redirect target by op class.
    always_comb begin
        cmp_eq_s    = (head_s.data == XLEN'(0));
        cmp_gt_s    = (head_s.data == XLEN'(2));
        cmp_lt_s    = (head_s.data == XLEN'(4));
        pc4_s       = head_s.pc + XLEN'(4);
        bt_s        = head_s.pc + head_s.imm;
        dec_wr_s    = 1'b0;
        dec_wdata_s = {XLEN{1'b0}};
        dec_redir_s = 1'b0;
        dec_tgt_s   = bt_s;
        case (head_s.op)
            4'd1: begin
                dec_wr_s    = 1'b1;
                dec_wdata_s = head_s.data;
            end
            4'd2, 4'd3: begin
                dec_wr_s    = 1'b1;
                dec_wdata_s = XLEN'(cmp_lt_s);
            end
            4'd4:       dec_redir_s = cmp_eq_s;
            4'd5:       dec_redir_s = !cmp_eq_s;
            4'd6, 4'd8: dec_redir_s = cmp_lt_s;
            4'd7, 4'd9: dec_redir_s = cmp_eq_s || cmp_gt_s;
            4'd10: begin
                dec_wr_s    = 1'b1;
                dec_wdata_s = pc4_s;
                dec_redir_s = 1'b1;
                dec_tgt_s   = head_s.data;
            end
            4'd11: begin
                dec_wr_s    = 1'b1;
                dec_wdata_s = pc4_s;
                dec_redir_s = 1'b1;
                dec_tgt_s   = head_s.data & ~XLEN'(1);
            end
            default: dec_wr_s = 1'b0;
        endcase
    end

    // FSM next state, registered output values and FIFO pointer bookkeeping.
    always_comb begin
        state_d  = state_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        rv_d     = rv_q;
        rpc_d    = rpc_q;
        pop_s    = 1'b0;
        flush_s  = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    wen_d   = dec_wr_s && (head_s.rd != 5'd0);
                    waddr_d = head_s.rd;
                    wdata_d = dec_wdata_s;
                    if (dec_redir_s) begin
                        rv_d    = 1'b1;
                        rpc_d   = dec_tgt_s;
                        state_d = REDIR;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REDIR: begin
                // Everything queued behind a redirect is wrong-path.
                if (redir_ready) begin
                    rv_d    = 1'b0;
                    flush_s = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = REDIR;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_s) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            wen_q    <= 1'b0;
            waddr_q  <= 5'd0;
            wdata_q  <= {XLEN{1'b0}};
            rv_q     <= 1'b0;
            rpc_q    <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            rv_q     <= rv_d;
            rpc_q    <= rpc_d;
        end
    end

    // FIFO storage; contents need no reset since the count qualifies them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= '{data: exu_data, op: wb_op, rd: rd, pc: pc, imm: imm};
        end
    end

    assign gpr_wen     = wen_q;
    assign gpr_waddr   = waddr_q;
    assign gpr_wdata   = wdata_q;
    assign redir_valid = rv_q;
    assign redir_pc    = rpc_q;

`ifdef WBU_ILLEGAL_CHK_EN
    logic ill_q, ill_d;

    // Flag compare results outside {0,2,4} on compare ops, and reserved op codes.
    always_comb begin
        ill_d = pop_s &&
                ((((head_s.op >= 4'd2) && (head_s.op <= 4'd9)) && !(cmp_eq_s || cmp_gt_s || cmp_lt_s))
                 || (head_s.op >= 4'd12));
    end

    // Illegal pulse register, aligned with the gpr_wen slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_q <= 1'b0;
        end else begin
            ill_q <= ill_d;
        end
    end

    assign illegal = ill_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_wbu.sv
// tb_wbu: directed and random stimulus for wbu, checked against a transaction-level queue model.
module tb_wbu;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] exu_data = 32'd0;
    logic [3:0]  wb_op = 4'd0;
    logic [4:0]  rd = 5'd0;
    logic [31:0] pc = 32'd0;
    logic [31:0] imm = 32'd0;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        redir_valid;
    logic        redir_ready = 1'b0;
    logic [31:0] redir_pc;
    logic        illegal;

    always #5 clk = ~clk;

    wbu #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .exu_data(exu_data), .wb_op(wb_op), .rd(rd), .pc(pc), .imm(imm),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
        .illegal(illegal)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
    } ent_t;

    ent_t        q[$];
    bit          m_redir = 1'b0;
    logic [31:0] m_rpc = 32'd0;
    logic        m_wen = 1'b0;
    logic [4:0]  m_waddr = 5'd0;
    logic [31:0] m_wdata = 32'd0;
    logic        m_ill = 1'b0;
    int          checks = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Spec-level resolution of one instruction result.
    function automatic void ref_resolve(input ent_t e, output logic wen, output logic [31:0] wdata,
                                        output logic redir, output logic [31:0] tgt, output logic ill);
        bit less  = (e.data == 32'd4);
        bit known = (e.data == 32'd0) || (e.data == 32'd2) || (e.data == 32'd4);
        wen = 1'b0; wdata = 32'd0; redir = 1'b0; tgt = 32'd0;
        case (e.op)
            4'd1:       begin wen = 1'b1; wdata = e.data; end
            4'd2, 4'd3: begin wen = 1'b1; wdata = less ? 32'd1 : 32'd0; end
            4'd4:       redir = (e.data == 32'd0);
            4'd5:       redir = (e.data != 32'd0);
            4'd6, 4'd8: redir = less;
            4'd7, 4'd9: redir = (e.data == 32'd0) || (e.data == 32'd2);
            4'd10:      begin wen = 1'b1; wdata = e.pc + 32'd4; redir = 1'b1; tgt = e.data; end
            4'd11:      begin wen = 1'b1; wdata = e.pc + 32'd4; redir = 1'b1; tgt = {e.data[31:1], 1'b0}; end
            default:    wen = 1'b0;
        endcase
        if (e.op >= 4'd4 && e.op <= 4'd9) tgt = e.pc + e.imm;
        if (e.rd == 5'd0) wen = 1'b0;
        ill = ((e.op >= 4'd2 && e.op <= 4'd9) && !known) || (e.op >= 4'd12);
    endfunction

    task automatic model_edge(input bit acc, input ent_t in_e);
        logic w, r, il;
        logic [31:0] wd, t;
        if (m_redir) begin
            m_wen = 1'b0; m_ill = 1'b0;
            if (redir_ready) begin
                q.delete();
                m_redir = 1'b0;
            end
        end else if (q.size() > 0) begin
            ent_t e = q.pop_front();
            ref_resolve(e, w, wd, r, t, il);
            m_wen = w; m_ill = il;
            if (w) begin m_waddr = e.rd; m_wdata = wd; end
            if (r) begin m_redir = 1'b1; m_rpc = t; end
        end else begin
            m_wen = 1'b0; m_ill = 1'b0;
        end
        if (acc) q.push_back(in_e);
    endtask

    task automatic check_outputs();
        logic exp_ill;
`ifdef WBU_ILLEGAL_CHK_EN
        exp_ill = m_ill;
`else
        exp_ill = 1'b0;
`endif
        chk("gpr_wen", gpr_wen, m_wen);
        if (m_wen) begin
            chk("gpr_waddr", gpr_waddr, m_waddr);
            chk("gpr_wdata", gpr_wdata, m_wdata);
        end
        chk("redir_valid", redir_valid, m_redir);
        if (m_redir) chk("redir_pc", redir_pc, m_rpc);
        chk("illegal", illegal, exp_ill);
    endtask

    // One clock: check in_ready, let the edge happen, update model, check outputs at negedge.
    task automatic cycle();
        bit   exp_ready, acc;
        ent_t e;
        #1;
        exp_ready = !m_redir && (q.size() < DEPTH);
        chk("in_ready", in_ready, exp_ready);
        acc = in_valid && exp_ready;
        e = '{data: exu_data, op: wb_op, rd: rd, pc: pc, imm: imm};
        @(posedge clk);
        model_edge(acc, e);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] d,
                         input logic [4:0] r, input logic [31:0] p, input logic [31:0] i);
        in_valid = v; wb_op = op; exu_data = d; rd = r; pc = p; imm = i;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 32'd0);
        chk("rst_gpr_wen", gpr_wen, 32'd0);
        chk("rst_gpr_waddr", gpr_waddr, 32'd0);
        chk("rst_gpr_wdata", gpr_wdata, 32'd0);
        chk("rst_redir_valid", redir_valid, 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        chk("rst_illegal", illegal, 32'd0);
        q.delete();
        m_redir = 1'b0; m_wen = 1'b0; m_ill = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        #2;
        do_reset();

        // ALU writeback
        drive(1'b1, 4'd1, 32'h1234, 5'd5, 32'h0, 32'h0);
        cycle();
        idle();
        cycle();
        chk("alu_wdata", gpr_wdata, 32'h1234);
        cycle();

        // SLT back-to-back
        drive(1'b1, 4'd2, 32'd4, 5'd7, 32'h0, 32'h0); cycle();
        drive(1'b1, 4'd2, 32'd2, 5'd7, 32'h0, 32'h0); cycle();
        drive(1'b1, 4'd2, 32'd0, 5'd7, 32'h0, 32'h0); cycle();
        idle(); cycle(); cycle();

        // Taken BLT held 3 cycles with younger entries behind it
        redir_ready = 1'b0;
        drive(1'b1, 4'd6, 32'd4, 5'd0, 32'h8000_0010, 32'hFFFF_FFF0); cycle();
        drive(1'b1, 4'd1, 32'h55, 5'd3, 32'h0, 32'h0); cycle();
        chk("blt_target", redir_pc, 32'h8000_0000);
        drive(1'b1, 4'd1, 32'h66, 5'd4, 32'h0, 32'h0); cycle();
        cycle();
        idle(); cycle();
        redir_ready = 1'b1; cycle();
        redir_ready = 1'b0; cycle(); cycle();

        // JALR
        drive(1'b1, 4'd11, 32'h2003, 5'd1, 32'h100, 32'h0); cycle();
        idle(); cycle();
        chk("jalr_wdata", gpr_wdata, 32'h104);
        chk("jalr_target", redir_pc, 32'h2002);
        redir_ready = 1'b1; cycle();
        redir_ready = 1'b0; cycle();

        // JAL to x0, pushes refused while redirecting, reset mid-redirect
        drive(1'b1, 4'd10, 32'h400, 5'd0, 32'h200, 32'h0); cycle();
        idle(); cycle();
        drive(1'b1, 4'd1, 32'h77, 5'd9, 32'h0, 32'h0); cycle();
        drive(1'b1, 4'd1, 32'h88, 5'd10, 32'h0, 32'h0); cycle();
        idle();
        do_reset();
        cycle();

        // BEQ with an out-of-range compare value
        drive(1'b1, 4'd4, 32'd6, 5'd9, 32'h40, 32'h20); cycle();
        idle(); cycle(); cycle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 4))
                0:       d = 32'd0;
                1:       d = 32'd2;
                2:       d = 32'd4;
                3:       d = $urandom_range(0, 7);
                default: d = $urandom;
            endcase
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), d,
                  5'($urandom_range(0, 31)), $urandom, $urandom);
            redir_ready = ($urandom_range(0, 2) == 0);
            cycle();
        end
        idle();
        redir_ready = 1'b1;
        cycle(); cycle(); cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
